// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges two execute lanes and a queued LSU result stream
// onto two registered register-file write ports.
module writeback_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int LQ_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex0_valid,
    input  logic [RF_ADDR_WIDTH-1:0] ex0_rd,
    input  logic [DATA_WIDTH-1:0]    ex0_data,
    input  logic                     ex1_valid,
    input  logic [RF_ADDR_WIDTH-1:0] ex1_rd,
    input  logic [DATA_WIDTH-1:0]    ex1_data,
    input  logic                     lsu_valid,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    output logic                     wEN_0,
    output logic [RF_ADDR_WIDTH-1:0] wAddr_0,
    output logic [DATA_WIDTH-1:0]    wData_0,
    output logic                     wEN_1,
    output logic [RF_ADDR_WIDTH-1:0] wAddr_1,
    output logic [DATA_WIDTH-1:0]    wData_1,
    output logic                     wb_busy
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [RF_ADDR_WIDTH-1:0] lq_rd_q   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0]    lq_data_q [LQ_DEPTH];
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    logic                     wen0_q, wen0_d, wen1_q, wen1_d, busy_q, busy_d;
    logic [RF_ADDR_WIDTH-1:0] waddr0_q, waddr0_d, waddr1_q, waddr1_d;
    logic [DATA_WIDTH-1:0]    wdata0_q, wdata0_d, wdata1_q, wdata1_d;

    logic [3:0]               cand_v_s;
    logic [RF_ADDR_WIDTH-1:0] cand_rd_s   [4];
    logic [DATA_WIDTH-1:0]    cand_data_s [4];
    logic                     have0_s, have1_s, collide_s, push_s;
    logic [1:0]               sel0_s, sel1_s, pop_cnt_s;
    logic [PW-1:0]            next_ptr_s;

    // A same-cycle pop does not raise ready: only the registered occupancy counts.
    assign lsu_ready = rst_n && (count_q < CW'(LQ_DEPTH));
    assign push_s    = lsu_valid && lsu_ready && (lsu_rd != {RF_ADDR_WIDTH{1'b0}});

    // Candidate list in priority order: ex0, ex1, FIFO head, FIFO head+1.
    always_comb begin
        next_ptr_s     = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        cand_v_s[0]    = ex0_valid && (ex0_rd != {RF_ADDR_WIDTH{1'b0}});
        cand_v_s[1]    = ex1_valid && (ex1_rd != {RF_ADDR_WIDTH{1'b0}});
        cand_v_s[2]    = (count_q >= CW'(1));
        cand_v_s[3]    = (count_q >= CW'(2));
        cand_rd_s[0]   = ex0_rd;
        cand_rd_s[1]   = ex1_rd;
        cand_rd_s[2]   = lq_rd_q[rd_ptr_q];
        cand_rd_s[3]   = lq_rd_q[next_ptr_s];
        cand_data_s[0] = ex0_data;
        cand_data_s[1] = ex1_data;
        cand_data_s[2] = lq_data_q[rd_ptr_q];
        cand_data_s[3] = lq_data_q[next_ptr_s];
    end

    // Pick the first two valid candidates; the second is always the younger one.
    always_comb begin
        have0_s = 1'b0;
        have1_s = 1'b0;
        sel0_s  = 2'd0;
        sel1_s  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cand_v_s[i]) begin
                if (!have0_s) begin
                    have0_s = 1'b1;
                    sel0_s  = 2'(i);
                end else if (!have1_s) begin
                    have1_s = 1'b1;
                    sel1_s  = 2'(i);
                end else begin
                    have1_s = have1_s;
                end
            end else begin
                have0_s = have0_s;
            end
        end
    end

    // Port contents, pop count and FIFO bookkeeping for the next cycle.
    always_comb begin
        collide_s = have0_s && have1_s && (cand_rd_s[sel0_s] == cand_rd_s[sel1_s]);
        pop_cnt_s = {1'b0, have0_s && sel0_s[1]} + {1'b0, have1_s && sel1_s[1]};
        wen0_d    = have0_s && !collide_s;
        wen1_d    = have1_s;
        if (wen0_d) begin
            waddr0_d = cand_rd_s[sel0_s];
            wdata0_d = cand_data_s[sel0_s];
        end else begin
            waddr0_d = {RF_ADDR_WIDTH{1'b0}};
            wdata0_d = {DATA_WIDTH{1'b0}};
        end
        if (wen1_d) begin
            waddr1_d = cand_rd_s[sel1_s];
            wdata1_d = cand_data_s[sel1_s];
        end else begin
            waddr1_d = {RF_ADDR_WIDTH{1'b0}};
            wdata1_d = {DATA_WIDTH{1'b0}};
        end
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt_s);
        wr_ptr_d = wr_ptr_q + PW'(push_s);
        count_d  = count_q + CW'(push_s) - CW'(pop_cnt_s);
        busy_d   = (count_d != {CW{1'b0}});
    end

    // Registered state and outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            wen0_q   <= 1'b0;
            waddr0_q <= {RF_ADDR_WIDTH{1'b0}};
            wdata0_q <= {DATA_WIDTH{1'b0}};
            wen1_q   <= 1'b0;
            waddr1_q <= {RF_ADDR_WIDTH{1'b0}};
            wdata1_q <= {DATA_WIDTH{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wen0_q   <= wen0_d;
            waddr0_q <= waddr0_d;
            wdata0_q <= wdata0_d;
            wen1_q   <= wen1_d;
            waddr1_q <= waddr1_d;
            wdata1_q <= wdata1_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; never written while in reset since lsu_ready is low then.
    always_ff @(posedge clk) begin
        if (push_s) begin
            lq_rd_q[wr_ptr_q]   <= lsu_rd;
            lq_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign wEN_0   = wen0_q;
    assign wAddr_0 = waddr0_q;
    assign wData_0 = wdata0_q;
    assign wEN_1   = wen1_q;
    assign wAddr_1 = waddr1_q;
    assign wData_1 = wdata1_q;
    assign wb_busy = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex0_valid, ex1_valid, lsu_valid;
    logic [AW-1:0] ex0_rd, ex1_rd, lsu_rd;
    logic [DW-1:0] ex0_data, ex1_data, lsu_data;
    logic          lsu_ready, wEN_0, wEN_1, wb_busy;
    logic [AW-1:0] wAddr_0, wAddr_1;
    logic [DW-1:0] wData_0, wData_1;

    int n_pass  = 0;
    int n_total = 0;

    ent_t          mq[$];
    logic          e_wen0, e_wen1, e_busy, e_ready;
    logic [AW-1:0] e_addr0, e_addr1;
    logic [DW-1:0] e_data0, e_data1;

    writeback_arbiter #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex0_valid(ex0_valid), .ex0_rd(ex0_rd), .ex0_data(ex0_data),
        .ex1_valid(ex1_valid), .ex1_rd(ex1_rd), .ex1_data(ex1_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .wEN_0(wEN_0), .wAddr_0(wAddr_0), .wData_0(wData_0),
        .wEN_1(wEN_1), .wAddr_1(wAddr_1), .wData_1(wData_1),
        .wb_busy(wb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One clock of the reference behaviour, evaluated on the current inputs.
    task automatic model_cycle();
        ent_t c[$];
        bit   f[$];
        int   pops;
        e_ready = rst_n && (mq.size() < DEPTH);
        e_wen0 = 1'b0; e_addr0 = '0; e_data0 = '0;
        e_wen1 = 1'b0; e_addr1 = '0; e_data1 = '0;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (ex0_valid && ex0_rd != 0) begin c.push_back('{ex0_rd, ex0_data}); f.push_back(1'b0); end
            if (ex1_valid && ex1_rd != 0) begin c.push_back('{ex1_rd, ex1_data}); f.push_back(1'b0); end
            for (int i = 0; i < mq.size() && i < 2; i++) begin
                c.push_back(mq[i]);
                f.push_back(1'b1);
            end
            pops = 0;
            if (c.size() >= 2) begin
                e_wen1 = 1'b1; e_addr1 = c[1].rd; e_data1 = c[1].data;
                if (c[0].rd != c[1].rd) begin
                    e_wen0 = 1'b1; e_addr0 = c[0].rd; e_data0 = c[0].data;
                end
                pops = int'(f[0]) + int'(f[1]);
            end else if (c.size() == 1) begin
                e_wen0 = 1'b1; e_addr0 = c[0].rd; e_data0 = c[0].data;
                pops = int'(f[0]);
            end
            repeat (pops) void'(mq.pop_front());
            if (lsu_valid && e_ready && lsu_rd != 0) mq.push_back('{lsu_rd, lsu_data});
        end
        e_busy = (mq.size() != 0);
    endtask

    task automatic step();
        #1;
        model_cycle();
        chk("lsu_ready", lsu_ready, e_ready);
        @(posedge clk);
        #1;
        chk("wEN_0", wEN_0, e_wen0);
        chk("wAddr_0", wAddr_0, e_addr0);
        chk("wData_0", wData_0, e_data0);
        chk("wEN_1", wEN_1, e_wen1);
        chk("wAddr_1", wAddr_1, e_addr1);
        chk("wData_1", wData_1, e_data1);
        chk("wb_busy", wb_busy, e_busy);
    endtask

    task automatic set_ex(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                          input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
        ex0_valid = v0; ex0_rd = r0; ex0_data = d0;
        ex1_valid = v1; ex1_rd = r1; ex1_data = d1;
    endtask

    task automatic set_lsu(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        lsu_valid = v; lsu_rd = r; lsu_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_lsu(1'b0, 5'd0, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Dual execute write.
        set_ex(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        step();
        chk("dual_addr0", wAddr_0, 5'd3);
        chk("dual_data1", wData_1, 32'hB);

        // Same-rd collision: younger lane wins on port 1.
        set_ex(1'b1, 5'd5, 32'd1, 1'b1, 5'd5, 32'd2);
        step();
        chk("coll_wen0", wEN_0, 1'b0);
        chk("coll_data1", wData_1, 32'd2);

        // LSU result queued behind two busy cycles.
        set_ex(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        set_lsu(1'b1, 5'd9, 32'h55);
        step();
        set_lsu(1'b0, 5'd0, 32'd0);
        step();
        chk("lsu_busy", wb_busy, 1'b1);
        step();
        set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        chk("lsu_addr0", wAddr_0, 5'd9);
        chk("lsu_data0", wData_0, 32'h55);

        // FIFO full, then drain two per cycle.
        set_ex(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int i = 0; i < 5; i++) begin
            set_lsu(1'b1, 5'(16 + i), 32'h100 + 32'(i));
            step();
        end
        chk("full_ready", lsu_ready, 1'b0);
        set_lsu(1'b0, 5'd0, 32'd0);
        set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (4) step();

        // Reset with three entries queued.
        set_ex(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int i = 0; i < 3; i++) begin
            set_lsu(1'b1, 5'(20 + i), 32'h200 + 32'(i));
            step();
        end
        set_lsu(1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();

        // rd = 0 filtering.
        set_ex(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        set_lsu(1'b1, 5'd0, 32'hBEEF);
        step();
        chk("rd0_busy", wb_busy, 1'b0);

        // Randomized traffic with phases of heavy and light lane use.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pct;
            pct       = ((cyc / 200) % 2 == 1) ? 90 : 40;
            rst_n     = ($urandom_range(0, 199) != 0);
            ex0_valid = ($urandom_range(0, 99) < pct);
            ex0_rd    = 5'($urandom_range(0, 15));
            ex0_data  = $urandom();
            ex1_valid = ($urandom_range(0, 99) < pct);
            ex1_rd    = ($urandom_range(0, 7) == 0) ? ex0_rd : 5'($urandom_range(0, 15));
            ex1_data  = $urandom();
            lsu_valid = ($urandom_range(0, 1) == 1);
            lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'(16 + $urandom_range(0, 3));
            lsu_data  = $urandom();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
